// File: rtl/pio_arb_pkg.sv
// ---------------------------------------------------------------------------
// pio_arb_pkg
// Shared types and defaults for the PIO instruction-memory arbiter.
//   NUM_SM_DEF / IMEM_AW / IMEM_DW : default SM count and 32x16 imem geometry
//   imem_addr_t, instr_t, sm_id_t  : address, instruction and SM index types
//   arb_src_e                      : which requester owns the RAM this cycle
// ---------------------------------------------------------------------------
package pio_arb_pkg;

    localparam int NUM_SM_DEF = 4;
    localparam int IMEM_AW    = 5;
    localparam int IMEM_DW    = 16;

    typedef logic [IMEM_AW-1:0]             imem_addr_t;
    typedef logic [IMEM_DW-1:0]             instr_t;
    typedef logic [$clog2(NUM_SM_DEF)-1:0]  sm_id_t;

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_WR,
        SRC_FETCH
    } arb_src_e;

endpackage

// File: rtl/pio_imem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches i_req upward starting at i_ptr,
// wrapping from N-1 to 0, and returns the first requester found.
//   i_req   : request vector
//   i_ptr   : search start index
//   o_gnt   : one-hot grant (zero when nothing requests)
//   o_valid : at least one request was found
// ---------------------------------------------------------------------------
module rr_pick
    import pio_arb_pkg::*;
#(
    parameter int N = NUM_SM_DEF
)
(
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic                 o_valid
);

    localparam int SW = $clog2(N);

    int             w_idx;
    logic [SW-1:0]  w_idx_s;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        w_idx_s = '0;
        for (int k = 0; k < N; k++) begin
            // Modular index without a divider; works for non-power-of-2 N.
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_idx_s = SW'(w_idx);
            if (!o_valid && i_req[w_idx_s]) begin
                o_gnt[w_idx_s] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_imem_arbiter.sv
// ---------------------------------------------------------------------------
// pio_imem_arbiter
// Shares the single-port PIO instruction memory between NUM_SM state-machine
// fetch ports and the host write path. Host writes win; fetches are granted
// round-robin. Read data returns one cycle after the grant, tagged with the
// winning SM via o_fetch_rvalid.
//
// Ports:
//   i_clk, i_reset       : clock, asynchronous active-high reset
//   i_sm_en              : per-SM enable (disabled requests are ignored)
//   i_fetch_req/addr     : fetch request and packed address (SM i at [i*AW +: AW])
//   o_fetch_gnt          : one-hot fetch grant, same cycle as the request
//   o_fetch_rvalid/rdata : one-hot read-valid and instruction word, cycle after grant
//   i_wr_req/addr/data   : host instruction write; o_wr_gnt when accepted
//   o_mem_*/i_mem_rdata  : single-port RAM interface (synchronous read)
//
// Optional build macro PIO_ARB_STARVE_GUARD_EN: after MAX_WR_BURST consecutive
// write grants with an enabled fetch pending, one fetch grant is forced.
// ---------------------------------------------------------------------------
module pio_imem_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_SM       = NUM_SM_DEF,
    parameter int AW           = IMEM_AW,
    parameter int DW           = IMEM_DW,
    parameter int MAX_WR_BURST = 4
)
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_SM-1:0]    i_sm_en,
    input  logic [NUM_SM-1:0]    i_fetch_req,
    input  logic [NUM_SM*AW-1:0] i_fetch_addr,
    output logic [NUM_SM-1:0]    o_fetch_gnt,
    output logic [NUM_SM-1:0]    o_fetch_rvalid,
    output logic [DW-1:0]        o_fetch_rdata,
    input  logic                 i_wr_req,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [DW-1:0]        i_wr_data,
    output logic                 o_wr_gnt,
    output logic [AW-1:0]        o_mem_addr,
    output logic [DW-1:0]        o_mem_wdata,
    output logic                 o_mem_wr,
    output logic                 o_mem_rd,
    input  logic [DW-1:0]        i_mem_rdata
);

    localparam int SW = $clog2(NUM_SM);

    logic [SW-1:0]     r_ptr;
    logic              r_rvalid_p1;
    logic [SW-1:0]     r_gnt_id_p1;

    logic [NUM_SM-1:0] w_req;
    logic [NUM_SM-1:0] w_pick_gnt;
    logic              w_pick_vld;
    logic [SW-1:0]     w_win_id;
    logic [SW-1:0]     w_ptr_nxt;
    logic              w_force_fetch;
    arb_src_e          w_src;

    assign w_req = i_fetch_req & i_sm_en;

    rr_pick #(.N(NUM_SM)) u_rr_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_vld)
    );

    always_comb begin
        w_win_id = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (w_pick_gnt[i]) begin
                w_win_id = SW'(i);
            end
        end
        w_ptr_nxt = (w_win_id == SW'(NUM_SM - 1)) ? '0 : w_win_id + 1'b1;
    end

`ifdef PIO_ARB_STARVE_GUARD_EN
    localparam int BW = $clog2(MAX_WR_BURST + 1);

    logic [BW-1:0] r_wr_burst;

    assign w_force_fetch = w_pick_vld && (r_wr_burst >= BW'(MAX_WR_BURST));

    // Counts write grants that stalled a pending fetch; saturates at the limit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_burst <= '0;
        end else if (!w_pick_vld || (w_src == SRC_FETCH)) begin
            r_wr_burst <= '0;
        end else if ((w_src == SRC_WR) && (r_wr_burst < BW'(MAX_WR_BURST))) begin
            r_wr_burst <= r_wr_burst + 1'b1;
        end
    end
`else
    assign w_force_fetch = 1'b0;
`endif

    // Stage p0: pick the single RAM owner for this cycle and drive the RAM.
    always_comb begin
        w_src       = SRC_IDLE;
        o_fetch_gnt = '0;
        o_wr_gnt    = 1'b0;
        o_mem_wr    = 1'b0;
        o_mem_rd    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (i_wr_req && !w_force_fetch) begin
            w_src = SRC_WR;
        end else if (w_pick_vld) begin
            w_src = SRC_FETCH;
        end
        case (w_src)
            SRC_WR: begin
                o_wr_gnt    = 1'b1;
                o_mem_wr    = 1'b1;
                o_mem_addr  = i_wr_addr;
                o_mem_wdata = i_wr_data;
            end
            SRC_FETCH: begin
                o_fetch_gnt = w_pick_gnt;
                o_mem_rd    = 1'b1;
                o_mem_addr  = i_fetch_addr[w_win_id*AW +: AW];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr       <= '0;
            r_rvalid_p1 <= 1'b0;
        end else begin
            r_rvalid_p1 <= (w_src == SRC_FETCH);
            if (w_src == SRC_FETCH) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // The grant id only matters while r_rvalid_p1 is set, so it is not reset.
    always_ff @(posedge i_clk) begin
        if (w_src == SRC_FETCH) begin
            r_gnt_id_p1 <= w_win_id;
        end
    end

    // Stage p1: RAM data returns; tag it with the SM granted last cycle.
    always_comb begin
        o_fetch_rvalid = '0;
        if (r_rvalid_p1) begin
            o_fetch_rvalid[r_gnt_id_p1] = 1'b1;
        end
    end

    assign o_fetch_rdata = i_mem_rdata;

    a_param_range: assert property (@(posedge i_clk)
        (NUM_SM >= 2) && (NUM_SM <= 8) && (MAX_WR_BURST >= 1));

    // A waiting requester must hold its address until it is granted.
    for (genvar g = 0; g < NUM_SM; g++) begin : g_addr_hold
        a_addr_hold: assert property (@(posedge i_clk) disable iff (i_reset)
            (w_req[g] && !o_fetch_gnt[g]) |=> $stable(i_fetch_addr[g*AW +: AW]));
    end

endmodule

// File: doc/pio_imem_arbiter.md
Name: pio_imem_arbiter

Overview:
- Shares the single-port 32x16 PIO instruction memory between NUM_SM state-machine instruction fetch ports and the host instruction-write path from the register block.
- Host writes have priority. State-machine fetches are granted round-robin.
- Read data returns one cycle after grant, tagged to the winning state machine.
- Sits between pio_regs/state machines and single_port_ram inside the pio top.

Parameters:
- NUM_SM, 4, number of state-machine fetch requesters (2..8)
- AW, 5, instruction memory address width
- DW, 16, instruction width
- MAX_WR_BURST, 4, consecutive host-write grants tolerated before a pending fetch is forced (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- sm_en  in  NUM_SM  per-SM enable; a disabled SM's request is ignored
- fetch_req  in  NUM_SM  fetch request; held high until granted
- fetch_addr  in  NUM_SM*AW  packed fetch address, SM i at [i*AW +: AW]
- fetch_gnt  out  NUM_SM  one-hot grant, same cycle as the request
- fetch_rvalid  out  NUM_SM  one-hot; data valid for that SM
- fetch_rdata  out  DW  instruction word; meaningful only when a bit of fetch_rvalid is set
- wr_req  in  1  host instruction-memory write request
- wr_addr  in  AW  host write address
- wr_data  in  DW  host write data
- wr_gnt  out  1  host write accepted this cycle
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_wr  out  1  RAM write strobe
- mem_rd  out  1  RAM read strobe
- mem_rdata  in  DW  RAM read data; synchronous, valid the cycle after mem_rd

Behaviour:
- Reset (async, active-high):
  - fetch_gnt=0, fetch_rvalid=0, wr_gnt=0, mem_wr=0, mem_rd=0.
  - RR pointer=0, rvalid pipeline cleared, write-burst count=0.
- Each cycle, at most one RAM access:
  - If wr_req: wr_gnt=1, mem_wr=1, mem_addr=wr_addr, mem_wdata=wr_data. No fetch grant.
  - Else if any (fetch_req & sm_en): the round-robin winner i is chosen. fetch_gnt[i]=1, mem_rd=1, mem_addr=fetch_addr[i].
  - Else idle; mem_addr=0.
- All grant and mem_* outputs are combinational from requests and registered state.
- Round-robin: search starts at pointer p and proceeds upward. After a fetch grant to i, p <= (i+1) mod NUM_SM. Wraps from NUM_SM-1 to 0. p is unchanged on write-only or idle cycles.
- Read latency: a fetch granted in cycle N gives fetch_rvalid[i]=1 and fetch_rdata=mem_rdata in cycle N+1 (registered grant id). fetch_rdata is passed through from mem_rdata.
- Back-to-back grants to different SMs are allowed every cycle, for full RAM throughput.
- Same-address write and fetch in the same cycle: the write wins. The fetch is granted in a later cycle and returns the new data.
- Disabled SM:
  - Its request is ignored and never granted.
  - If disabled in the cycle after its grant, its rvalid is still delivered.
- Reset mid-operation: the pending rvalid is dropped, with no spurious rvalid after reset deasserts.
- An SM must not change fetch_addr while fetch_req is high and ungranted. This is checked by an assertion.

Optional Feature:
- Macro PIO_ARB_STARVE_GUARD_EN.
- When defined:
  - A saturating counter counts consecutive wr_gnt cycles while any enabled fetch is pending.
  - When the count reaches MAX_WR_BURST, the next cycle grants the RR fetch winner instead, with wr_gnt=0 and the write stalled.
  - The counter clears on any fetch grant or when no fetch is pending.
- When undefined: host writes always win and the counter logic is absent.

Decomposition:
- Package pio_arb_pkg:
  - localparams NUM_SM_DEF=4, IMEM_AW=5, IMEM_DW=16
  - typedefs imem_addr_t, instr_t, sm_id_t (clog2 of NUM_SM)
  - typedef arb_src_e {SRC_IDLE, SRC_WR, SRC_FETCH}
- One sub-module, rr_pick: a combinational round-robin picker taking req vector and pointer, returning a one-hot grant and a valid flag.
- Pointer and pipeline registers stay in pio_imem_arbiter.

Test Plan:
1. Reset, then SM0 fetch addr 3 with RAM[3]=16'hE081 -> fetch_gnt=0001 in cycle N; fetch_rvalid=0001, fetch_rdata=E081 in cycle N+1.
2. All 4 SMs request continuously -> grants 0,1,2,3,0,1 in consecutive cycles, each rvalid one cycle later; the pointer wraps 3→0.
3. wr_req addr 5 data 16'hA042 in the same cycle as SM2 fetch addr 5 -> wr_gnt=1 and no fetch grant; SM2 granted next cycle and returns A042.
4. sm_en=1011 with all requesting -> SM2 never granted; grant order 0,1,3,0.
5. Reset asserted the cycle after an SM1 grant -> fetch_rvalid stays 0 through and after reset; pointer=0.
6. With PIO_ARB_STARVE_GUARD_EN and MAX_WR_BURST=4: continuous wr_req while SM0 requests -> 4 wr_gnt cycles, then fetch_gnt=0001, then writes resume. Without the macro: SM0 is starved for as long as writes continue.
